fejkon_pcie_tx_gearbox: RTL and testbench
=========================================

Name: fejkon_pcie_tx_gearbox

Overview:
Downstream stage of fejkon_pcie_data. Consumes the 256-bit, channelised data_tx Avalon-ST packet stream and serialises each beat into 32-bit words for the per-port Fibre Channel transmit path. The block removes empty bytes at packet end, carries the channel, and preserves SOP and EOP framing. It also keeps a packet counter and a sticky protocol-error flag for CSR readout.

Parameters:
IN_WIDTH, 256, input data width in bits; must be a multiple of OUT_WIDTH.
OUT_WIDTH, 32, output data width in bits (4 bytes).
CHANNEL_WIDTH, 2, channel field width.

Ports:
clk  in  1  single clock for all logic.
reset  in  1  asynchronous, active-high reset.
data_tx_data  in  256  input beat; first symbol in bits [255:248].
data_tx_valid  in  1  input beat valid.
data_tx_ready  out  1  input beat accepted when valid && ready.
data_tx_channel  in  2  destination channel; sampled at SOP.
data_tx_startofpacket  in  1  first beat of packet.
data_tx_endofpacket  in  1  last beat of packet.
data_tx_empty  in  5  empty bytes in the EOP beat; ignored on other beats.
out_data  out  32  output word; first byte in [31:24].
out_valid  out  1  output word valid.
out_ready  in  1  downstream accepts when valid && ready.
out_channel  out  2  channel latched at SOP.
out_startofpacket  out  1  first word of packet.
out_endofpacket  out  1  last word of packet.
out_empty  out  2  empty bytes in the EOP word; 0 otherwise.
pkt_count  out  32  packets fully emitted (EOP word accepted); wraps at 2^32-1 to 0.
proto_err  out  1  sticky protocol-error flag; cleared only by reset.

Behaviour:
- Reset, asynchronous: state IDLE; out_valid=0, out_data=0, out_channel=0, out_startofpacket=0, out_endofpacket=0, out_empty=0; pkt_count=0; proto_err=0; in_pkt=0. While reset is high, data_tx_ready=0.
- States: IDLE (no beat held) and SHIFT (beat held in a 256-bit holding register; word index idx runs 0..last_idx).
- data_tx_ready = (state==IDLE) || (out_valid && out_ready && idx==last_idx). This allows back-to-back beats with no bubble.
- Beat accept in cycle N:
  - Load the holding register and set idx=0.
  - last_idx = eop ? (31-empty)>>2 : 7.
  - Word 0 appears on out_* in cycle N+1. Latency is 1 cycle.
- Output word k = hold[255-32k -: 32].
  - out_startofpacket=1 only on word 0 of an SOP beat.
  - out_endofpacket=1 only on word last_idx of an EOP beat.
  - out_empty = eop_word ? empty[1:0] : 0.
- Word advance:
  - On out_valid && out_ready with idx<last_idx: idx+1.
  - At idx==last_idx: load the next beat if one is accepted in the same cycle; otherwise go to IDLE with out_valid=0.
- Backpressure: while out_valid && !out_ready, every out_* signal holds stable.
- Channel: latched on an SOP beat accept and held through EOP.
- Protocol errors (proto_err is set; data is still forwarded):
  - SOP while in_pkt=1.
  - Non-SOP beat while in_pkt=0. The beat is forwarded with the previously latched channel.
  - data_tx_channel differs from the latched channel on a non-SOP beat. The latched channel is kept.
- in_pkt tracking: set on accept of an SOP beat without EOP; cleared on accept of an EOP beat. A single-beat SOP+EOP packet leaves in_pkt=0.
- pkt_count increments in the cycle the EOP word handshakes, not at input accept.
- Reset mid-packet: the held beat is discarded, and output restarts clean in IDLE.

Test Plan:
1. Single-beat packet: SOP+EOP, empty=0, data=0x00010203..1F, channel=2, out_ready=1. Expect 8 words 0x00010203..0x1C1D1E1F on consecutive cycles, SOP on word 0, EOP on word 7, out_empty=0, out_channel=2, pkt_count=1.
2. Empty boundaries: SOP+EOP with empty=31 gives 1 word with SOP+EOP and out_empty=3. With empty=28 it gives 1 word with out_empty=0. With empty=3 it gives 8 words, last out_empty=3.
3. Three-beat packet, data_tx_valid held high, out_ready=1. Expect data_tx_ready to pulse every 8 cycles, 24 gap-free words, and EOP only on the final word.
4. Random out_ready (50%) on the test-3 stream. Expect out_* stable whenever stalled, no words lost or duplicated, and the word sequence identical to test 3.
5. Protocol errors: SOP beat without EOP, then a second SOP beat. Expect proto_err=1 and both beats forwarded. Separately, a mid-packet channel change 1→3 gives proto_err=1 with out_channel staying 1.
6. Reset mid-packet: assert reset during word 4. Expect out_valid=0 immediately and pkt_count=0. After release, a fresh packet is emitted correctly starting from word 0.

Source files
------------

// File: rtl/fejkon_pcie_tx_gearbox.sv
// fejkon_pcie_tx_gearbox
// Serialises wide channelised Avalon-ST beats into narrow words for the
// Fibre Channel transmit path. Trailing empty bytes of the EOP beat are
// dropped at word granularity; the residue within the final word is reported
// on out_empty. Keeps a packet counter and a sticky framing-error flag.
// Assumes IN_WIDTH/OUT_WIDTH and OUT_WIDTH/8 are powers of two, with at
// least two words per beat.

module fejkon_pcie_tx_gearbox #(
  parameter int IN_WIDTH      = 256,
  parameter int OUT_WIDTH     = 32,
  parameter int CHANNEL_WIDTH = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [IN_WIDTH-1:0]              data_tx_data,
  input  logic                             data_tx_valid,
  output logic                             data_tx_ready,
  input  logic [CHANNEL_WIDTH-1:0]         data_tx_channel,
  input  logic                             data_tx_startofpacket,
  input  logic                             data_tx_endofpacket,
  input  logic [$clog2(IN_WIDTH/8)-1:0]    data_tx_empty,
  output logic [OUT_WIDTH-1:0]             out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [CHANNEL_WIDTH-1:0]         out_channel,
  output logic                             out_startofpacket,
  output logic                             out_endofpacket,
  output logic [$clog2(OUT_WIDTH/8)-1:0]   out_empty,
  output logic [31:0]                      pkt_count,
  output logic                             proto_err
);

  localparam int WORDS       = IN_WIDTH / OUT_WIDTH;
  localparam int IN_BYTES    = IN_WIDTH / 8;
  localparam int IDX_W       = $clog2(WORDS);
  localparam int EMPTY_W     = $clog2(IN_BYTES);
  localparam int OUT_EMPTY_W = $clog2(OUT_WIDTH / 8);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                              state_q, state_d;
  logic [WORDS-1:0][OUT_WIDTH-1:0]     hold_q;
  logic [IDX_W-1:0]                    idx_q, last_idx_q;
  logic                                beat_sop_q, beat_eop_q;
  logic [OUT_EMPTY_W-1:0]              beat_empty_q;
  logic [CHANNEL_WIDTH-1:0]            channel_q;
  logic                                in_pkt_q;

  logic                                out_fire;
  logic                                last_word;
  logic                                word_done;
  logic                                accept;
  logic                                beat_err;
  logic [EMPTY_W-1:0]                  valid_bytes_m1;
  logic [IDX_W-1:0]                    last_idx_in;
  logic [IDX_W-1:0]                    word_sel;

  assign out_fire  = out_valid && out_ready;
  assign last_word = (idx_q == last_idx_q);
  assign word_done = out_fire && last_word;

  // A new beat is taken when nothing is held, or in the same cycle the final
  // word of the held beat leaves, so consecutive beats stream without a bubble.
  assign data_tx_ready = !reset && ((state_q == IDLE) || word_done);
  assign accept        = data_tx_valid && data_tx_ready;

  // Index of the last word carrying data: (valid bytes - 1) / bytes per word.
  assign valid_bytes_m1 = EMPTY_W'(IN_BYTES - 1) - data_tx_empty;
  assign last_idx_in    = data_tx_endofpacket ? valid_bytes_m1[EMPTY_W-1:OUT_EMPTY_W]
                                              : IDX_W'(WORDS - 1);

  // First symbol sits in the top bits, so word 0 is the highest array entry.
  assign word_sel = IDX_W'(WORDS - 1) - idx_q;

  assign beat_err = data_tx_startofpacket
                  ? in_pkt_q
                  : (!in_pkt_q || (data_tx_channel != channel_q));

  assign out_channel = channel_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: hold a beat from accept until its last word handshakes.
  always_comb begin
    // NOTE: defaulting every comb output first means no path leaves it
    // unassigned, so no latch can be inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (word_done && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the held beat and current word index.
  always_comb begin
    out_valid         = 1'b0;
    out_data          = '0;
    out_startofpacket = 1'b0;
    out_endofpacket   = 1'b0;
    out_empty         = '0;
    if (state_q == SHIFT) begin
      out_valid         = 1'b1;
      out_data          = hold_q[word_sel];
      out_startofpacket = beat_sop_q && (idx_q == '0);
      out_endofpacket   = beat_eop_q && last_word;
      out_empty         = (beat_eop_q && last_word) ? beat_empty_q : '0;
    end
  end

  // Beat payload capture.
  always_ff @(posedge clk) begin
    // NOTE: the payload register is deliberately not reset; it is only read
    // while in SHIFT, which is entered solely by loading it.
    if (accept) hold_q <= data_tx_data;
  end

  // Per-beat framing, word index and channel latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q        <= '0;
      last_idx_q   <= '0;
      beat_sop_q   <= 1'b0;
      beat_eop_q   <= 1'b0;
      beat_empty_q <= '0;
      channel_q    <= '0;
    end else if (accept) begin
      idx_q        <= '0;
      last_idx_q   <= last_idx_in;
      beat_sop_q   <= data_tx_startofpacket;
      beat_eop_q   <= data_tx_endofpacket;
      beat_empty_q <= data_tx_empty[OUT_EMPTY_W-1:0];
      if (data_tx_startofpacket) channel_q <= data_tx_channel;
    end else if (out_fire && !last_word) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  // Packet tracking, completed-packet counter and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_pkt_q  <= 1'b0;
      pkt_count <= '0;
      proto_err <= 1'b0;
    end else begin
      if (accept) begin
        if (data_tx_endofpacket)        in_pkt_q <= 1'b0;
        else if (data_tx_startofpacket) in_pkt_q <= 1'b1;
        if (beat_err) proto_err <= 1'b1;
      end
      if (word_done && beat_eop_q) pkt_count <= pkt_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fejkon_pcie_tx_gearbox.sv
// Self-checking bench for fejkon_pcie_tx_gearbox: a table of single-beat
// packets, hand-written framing/reset sequences, and randomized streams
// scored against a byte-level reference model.

module tb_fejkon_pcie_tx_gearbox;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [255:0] data_tx_data = '0;
  logic         data_tx_valid = 1'b0;
  logic         data_tx_ready;
  logic [1:0]   data_tx_channel = '0;
  logic         data_tx_startofpacket = 1'b0;
  logic         data_tx_endofpacket = 1'b0;
  logic [4:0]   data_tx_empty = '0;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [1:0]   out_channel;
  logic         out_startofpacket;
  logic         out_endofpacket;
  logic [1:0]   out_empty;
  logic [31:0]  pkt_count;
  logic         proto_err;

  fejkon_pcie_tx_gearbox dut (
    .clk                   (clk),
    .reset                 (reset),
    .data_tx_data          (data_tx_data),
    .data_tx_valid         (data_tx_valid),
    .data_tx_ready         (data_tx_ready),
    .data_tx_channel       (data_tx_channel),
    .data_tx_startofpacket (data_tx_startofpacket),
    .data_tx_endofpacket   (data_tx_endofpacket),
    .data_tx_empty         (data_tx_empty),
    .out_data              (out_data),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .out_channel           (out_channel),
    .out_startofpacket     (out_startofpacket),
    .out_endofpacket       (out_endofpacket),
    .out_empty             (out_empty),
    .pkt_count             (pkt_count),
    .proto_err             (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] data;
    logic [1:0]   ch;
    logic         sop;
    logic         eop;
    logic [4:0]   empty;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  ch;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
  } word_t;

  typedef struct {
    logic [4:0]  empty;
    logic [1:0]  ch;
    int          exp_words;
    logic [31:0] exp_last_data;
    logic [1:0]  exp_last_empty;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  word_t       exp_q[$];
  logic [1:0]  m_ch;
  logic        m_in_pkt;
  logic        exp_err;
  logic [31:0] exp_pkt;
  int          words_seen;
  logic        stalled;
  word_t       held;
  word_t       last_got;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Expand an accepted beat into the words it must produce, byte by byte.
  task automatic model_accept(input beat_t b);
    int    nbytes, nwords;
    word_t w;
    if (b.sop && m_in_pkt) exp_err = 1'b1;
    if (!b.sop && !m_in_pkt) exp_err = 1'b1;
    if (!b.sop && (b.ch != m_ch)) exp_err = 1'b1;
    if (b.sop) m_ch = b.ch;
    nbytes = b.eop ? 32 - int'(b.empty) : 32;
    nwords = (nbytes + 3) / 4;
    for (int k = 0; k < nwords; k++) begin
      for (int j = 0; j < 4; j++)
        w.data[31-8*j -: 8] = b.data[255-8*(4*k+j) -: 8];
      w.ch    = m_ch;
      w.sop   = b.sop && (k == 0);
      w.eop   = b.eop && (k == nwords - 1);
      w.empty = w.eop ? 2'(4 * nwords - nbytes) : 2'd0;
      exp_q.push_back(w);
    end
    if (b.eop)      m_in_pkt = 1'b0;
    else if (b.sop) m_in_pkt = 1'b1;
  endtask

  // One clock: compare at the falling edge, update the model, return after
  // the rising edge so the caller can drive the next cycle's inputs.
  task automatic tick(output bit accepted);
    word_t got, w;
    beat_t b;
    @(negedge clk);
    got.data = out_data; got.ch = out_channel; got.sop = out_startofpacket;
    got.eop = out_endofpacket; got.empty = out_empty;
    check("pkt_count", pkt_count, exp_pkt);
    check("proto_err", proto_err, exp_err);
    check("out_valid", out_valid, exp_q.size() != 0);
    check("data_tx_ready", data_tx_ready, (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready));
    if (stalled && out_valid)
      check("stall_hold", {got.data, got.ch, got.sop, got.eop, got.empty},
                          {held.data, held.ch, held.sop, held.eop, held.empty});
    if (out_valid && out_ready && exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check("word_data", got.data, w.data);
      check("word_channel", got.ch, w.ch);
      check("word_sop", got.sop, w.sop);
      check("word_eop", got.eop, w.eop);
      check("word_empty", got.empty, w.empty);
      if (w.eop) exp_pkt = exp_pkt + 32'd1;
      words_seen++;
      last_got = got;
    end
    stalled = out_valid && !out_ready;
    held = got;
    accepted = data_tx_valid && data_tx_ready;
    if (accepted) begin
      b.data = data_tx_data; b.ch = data_tx_channel; b.sop = data_tx_startofpacket;
      b.eop = data_tx_endofpacket; b.empty = data_tx_empty;
      model_accept(b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    data_tx_valid = 1'b0;
    out_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_ready", data_tx_ready, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_sop", out_startofpacket, 1'b0);
    check("rst_out_eop", out_endofpacket, 1'b0);
    check("rst_out_empty", out_empty, 2'd0);
    check("rst_out_channel", out_channel, 2'd0);
    check("rst_pkt_count", pkt_count, 32'd0);
    check("rst_proto_err", proto_err, 1'b0);
    exp_q.delete();
    m_ch = '0; m_in_pkt = 1'b0; exp_err = 1'b0; exp_pkt = '0;
    stalled = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic send_beats(input beat_t beats[$], input int ready_pct, input int valid_pct);
    int i = 0;
    int budget = 4000;
    bit acc;
    while (i < beats.size() && budget > 0) begin
      data_tx_data = beats[i].data; data_tx_channel = beats[i].ch;
      data_tx_startofpacket = beats[i].sop; data_tx_endofpacket = beats[i].eop;
      data_tx_empty = beats[i].empty;
      data_tx_valid = (valid_pct >= 100) ? 1'b1 : ($urandom_range(99) < valid_pct);
      out_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);
      tick(acc);
      if (acc) i++;
      budget--;
    end
    data_tx_valid = 1'b0;
    while (exp_q.size() != 0 && budget > 0) begin
      out_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);
      tick(acc);
      budget--;
    end
    check("stream_timeout", (i < beats.size()) || (exp_q.size() != 0), 1'b0);
  endtask

  function automatic beat_t mk_beat(input logic [255:0] d, input logic [1:0] ch,
                                    input logic sop, input logic eop, input logic [4:0] empty);
    beat_t b;
    b.data = d; b.ch = ch; b.sop = sop; b.eop = eop; b.empty = empty;
    return b;
  endfunction

  function automatic logic [255:0] rand_data();
    logic [255:0] d;
    for (int w = 0; w < 8; w++) d[32*w +: 32] = $urandom;
    return d;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    logic [255:0] ramp;
    vec_t         vecs[5];
    beat_t        bq[$];
    bit           acc;
    int           budget;
    int           w0;

    for (int i = 0; i < 32; i++) ramp[255-8*i -: 8] = 8'(i);

    // empty, channel, words, last word data, last out_empty
    vecs[0] = '{5'd0,  2'd2, 8, 32'h1C1D1E1F, 2'd0};
    vecs[1] = '{5'd31, 2'd1, 1, 32'h00010203, 2'd3};
    vecs[2] = '{5'd28, 2'd0, 1, 32'h00010203, 2'd0};
    vecs[3] = '{5'd3,  2'd3, 8, 32'h1C1D1E1F, 2'd3};
    vecs[4] = '{5'd17, 2'd2, 4, 32'h0C0D0E0F, 2'd1};

    #1;
    do_reset();

    // Single-beat packets across the empty boundaries
    for (int v = 0; v < 5; v++) begin
      do_reset();
      w0 = words_seen;
      bq.delete();
      bq.push_back(mk_beat(ramp, vecs[v].ch, 1'b1, 1'b1, vecs[v].empty));
      send_beats(bq, 100, 100);
      check("vec_words", words_seen - w0, vecs[v].exp_words);
      check("vec_last_data", last_got.data, vecs[v].exp_last_data);
      check("vec_last_empty", last_got.empty, vecs[v].exp_last_empty);
      check("vec_last_eop", last_got.eop, 1'b1);
      check("vec_channel", last_got.ch, vecs[v].ch);
      check("vec_pkt_count", pkt_count, 32'd1);
    end

    // Three-beat packet, streaming then with random backpressure
    bq.delete();
    bq.push_back(mk_beat(rand_data(), 2'd1, 1'b1, 1'b0, 5'd9));
    bq.push_back(mk_beat(rand_data(), 2'd1, 1'b0, 1'b0, 5'd22));
    bq.push_back(mk_beat(rand_data(), 2'd1, 1'b0, 1'b1, 5'd0));
    do_reset();
    w0 = words_seen;
    send_beats(bq, 100, 100);
    check("stream_words", words_seen - w0, 24);
    do_reset();
    w0 = words_seen;
    send_beats(bq, 50, 100);
    check("stall_words", words_seen - w0, 24);
    check("stall_pkt_count", pkt_count, 32'd1);

    // SOP arriving while a packet is open
    do_reset();
    w0 = words_seen;
    bq.delete();
    bq.push_back(mk_beat(rand_data(), 2'd0, 1'b1, 1'b0, 5'd0));
    bq.push_back(mk_beat(rand_data(), 2'd2, 1'b1, 1'b1, 5'd0));
    send_beats(bq, 100, 100);
    check("dup_sop_err", proto_err, 1'b1);
    check("dup_sop_words", words_seen - w0, 16);

    // Channel change mid-packet keeps the latched channel
    do_reset();
    bq.delete();
    bq.push_back(mk_beat(rand_data(), 2'd1, 1'b1, 1'b0, 5'd0));
    bq.push_back(mk_beat(rand_data(), 2'd3, 1'b0, 1'b0, 5'd0));
    bq.push_back(mk_beat(rand_data(), 2'd1, 1'b0, 1'b1, 5'd4));
    send_beats(bq, 100, 100);
    check("chan_err", proto_err, 1'b1);
    check("chan_kept", out_channel, 2'd1);

    // Non-SOP beat with no open packet
    do_reset();
    bq.delete();
    bq.push_back(mk_beat(rand_data(), 2'd0, 1'b0, 1'b1, 5'd12));
    send_beats(bq, 100, 100);
    check("orphan_err", proto_err, 1'b1);

    // Reset while word 4 of a held beat is on the output
    do_reset();
    w0 = words_seen;
    data_tx_data = ramp; data_tx_channel = 2'd2;
    data_tx_startofpacket = 1'b1; data_tx_endofpacket = 1'b0; data_tx_empty = '0;
    data_tx_valid = 1'b1;
    out_ready = 1'b1;
    budget = 50;
    while (words_seen - w0 < 4 && budget > 0) begin
      tick(acc);
      if (acc) data_tx_valid = 1'b0;
      budget--;
    end
    check("mid_reset_reach", words_seen - w0, 4);
    check("mid_reset_word4_valid", out_valid, 1'b1);
    do_reset();
    w0 = words_seen;
    bq.delete();
    bq.push_back(mk_beat(ramp, 2'd3, 1'b1, 1'b1, 5'd0));
    send_beats(bq, 100, 100);
    check("post_reset_words", words_seen - w0, 8);
    check("post_reset_pkt", pkt_count, 32'd1);

    // Randomized well-framed traffic with bubbles and backpressure
    do_reset();
    bq.delete();
    for (int p = 0; p < 16; p++) begin
      int         nb;
      logic [1:0] ch;
      nb = $urandom_range(1, 4);
      ch = 2'($urandom);
      for (int b = 0; b < nb; b++)
        bq.push_back(mk_beat(rand_data(), ch, b == 0, b == nb - 1, 5'($urandom)));
    end
    send_beats(bq, 60, 70);
    check("rand_pkt_count", pkt_count, 32'd16);
    check("rand_no_err", proto_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
